instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: fetch PC, single outstanding imem request, 2-entry {pc, instr} FIFO to decode.
// Optional FETCH_MISALIGN_EN adds a sticky misaligned-redirect flag that halts fetching until reset.
module instr_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  input  logic             out_ready
`ifdef FETCH_MISALIGN_EN
  ,
  output logic             misalign
`endif
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DROP
  } state_e;

  state_e                     state_q, state_d;
  logic [WIDTH-1:0]           pc_q, pc_d;
  logic [WIDTH-1:0]           req_pc_q, req_pc_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic [1:0][WIDTH-1:0]      ent_pc_q, ent_pc_d;
  logic [1:0][WIDTH-1:0]      ent_instr_q, ent_instr_d;
  logic                       misal_q, misal_d;

  logic             accept;
  logic             push;
  logic             pop;
  logic             redir_bad;
  logic [WIDTH-1:0] redir_pc;

`ifdef FETCH_MISALIGN_EN
  assign redir_pc  = redirect_pc;
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc  = redirect_pc & ~WIDTH'(3);
  assign redir_bad = 1'b0;
`endif

  // Only RUN has no response in flight, so count<2 already covers the slot reservation.
  assign imem_req_valid = (state_q == S_RUN) && !rst && (cnt_q < 2'd2) && !misal_q;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;

  assign out_valid = !rst && (cnt_q != 2'd0);
  assign out_instr = rst ? '0 : ent_instr_q[0];
  assign out_pc    = rst ? '0 : ent_pc_q[0];
  assign pop       = out_valid && out_ready;

`ifdef FETCH_MISALIGN_EN
  assign misalign = !rst && misal_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (accept) state_d = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_d = S_RUN;
      S_DROP:  if (imem_rsp_valid) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
    // A redirect turns any in-flight response into one to throw away.
    if (redirect_valid) begin
      if (state_q == S_RUN) state_d = accept ? S_DROP : S_RUN;
      else                  state_d = imem_rsp_valid ? S_RUN : S_DROP;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (accept) begin
      pc_d     = pc_q + WIDTH'(4);
      req_pc_d = pc_q;
    end
    if (redirect_valid) pc_d = redir_pc;
    misal_d = misal_q | redir_bad;
  end

  always_comb begin
    cnt_d       = cnt_q;
    ent_pc_d    = ent_pc_q;
    ent_instr_d = ent_instr_q;
    if (redirect_valid) begin
      cnt_d = 2'd0;
    end else if (push && pop) begin
      if (cnt_q == 2'd2) begin
        ent_pc_d[0]    = ent_pc_q[1];
        ent_instr_d[0] = ent_instr_q[1];
        ent_pc_d[1]    = req_pc_q;
        ent_instr_d[1] = imem_rsp_data;
      end else begin
        ent_pc_d[0]    = req_pc_q;
        ent_instr_d[0] = imem_rsp_data;
      end
    end else if (push) begin
      ent_pc_d[cnt_q[0]]    = req_pc_q;
      ent_instr_d[cnt_q[0]] = imem_rsp_data;
      cnt_d                 = cnt_q + 2'd1;
    end else if (pop) begin
      ent_pc_d[0]    = ent_pc_q[1];
      ent_instr_d[0] = ent_instr_q[1];
      cnt_d          = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      cnt_q       <= 2'd0;
      ent_pc_q    <= '0;
      ent_instr_q <= '0;
      misal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      cnt_q       <= cnt_d;
      ent_pc_q    <= ent_pc_d;
      ent_instr_q <= ent_instr_d;
      misal_q     <= misal_d;
    end
  end

endmodule
